spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_pkg.sv | 11 +
 rtl/spi_sync_edge.sv | 29 ++
 rtl/spi_slave.sv | 169 ++++++++++++++++
 tb/tb_spi_slave.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared SPI slave definitions: FSM state encoding and default word width.
package spi_slave_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 16;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus edge-detect flop for one asynchronous input.
// Latency: q_o and rise_o/fall_o valid 2 clk edges after the pin changes.
// Backpressure: none, free-running.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {3{RST_VAL}};
        end else begin
            sync_q <= {sync_q[1:0], d_i};
        end
    end

    assign q_o    = sync_q[1];
    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: MSB-first word shifter with a one-deep tx shadow register.
// Latency: rx_valid rises 3 clk edges after the pin sclk rise that completes a word.
// Backpressure: tx_ready low while the shadow holds a word; further tx_load is ignored.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic              frame_err
);

    localparam int               CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    logic ss_s, ss_rise, ss_fall;
    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .d_i(ss),
        .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(sclk),
        .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(mosi),
        .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic              tx_ready_q, tx_ready_d;
    logic              reload_q, reload_d;
    logic              frame_err_q, frame_err_d;
    logic              miso_q, miso_d;
    logic [1:0]        settle_q, settle_d;
    logic              armed_q, armed_d;
    logic [DATA_W-1:0] tx_fill;
    logic              tx_reg_load;

    // An empty shadow with a simultaneous tx_load hands tx_data straight to the shifter.
    assign tx_fill = tx_ready_q ? (tx_load ? tx_data : '0) : shadow_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_sr_d     = rx_sr_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_sr_d     = tx_sr_q;
        shadow_d    = shadow_q;
        tx_ready_d  = tx_ready_q;
        reload_d    = reload_q;
        frame_err_d = 1'b0;
        tx_reg_load = 1'b0;
        settle_d    = {settle_q[0], 1'b1};
        // Only arm once ss is seen high after the synchronizer has flushed its reset value.
        armed_d     = armed_q | (settle_q[1] & ss_s);

        case (state_q)
            IDLE: begin
                if (ss_fall && armed_q) begin
                    state_d     = SHIFT;
                    cnt_d       = '0;
                    rx_sr_d     = '0;
                    reload_d    = 1'b0;
                    tx_sr_d     = tx_fill;
                    tx_reg_load = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d     = IDLE;
                    frame_err_d = (cnt_q != '0);
                    cnt_d       = '0;
                    rx_sr_d     = '0;
                end else begin
                    if (sclk_rise) begin
                        rx_sr_d = {rx_sr_q[DATA_W-2:0], mosi_s};
                        if (cnt_q == LAST) begin
                            rx_data_d  = rx_sr_d;
                            rx_valid_d = 1'b1;
                            cnt_d      = '0;
                            reload_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    if (sclk_fall) begin
                        if (reload_q) begin
                            tx_sr_d     = tx_fill;
                            tx_reg_load = 1'b1;
                            reload_d    = 1'b0;
                        end else begin
                            tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (tx_reg_load) begin
            tx_ready_d = 1'b1;
        end else if (tx_load && tx_ready_q) begin
            shadow_d   = tx_data;
            tx_ready_d = 1'b0;
        end

        miso_d = (state_d == SHIFT) ? tx_sr_d[DATA_W-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_sr_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_sr_q     <= '0;
            shadow_q    <= '0;
            tx_ready_q  <= 1'b1;
            reload_q    <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
            settle_q    <= '0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_sr_q     <= rx_sr_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_sr_q     <= tx_sr_d;
            shadow_q    <= shadow_d;
            tx_ready_q  <= tx_ready_d;
            reload_q    <= reload_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
        end
    end

    assign miso      = miso_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_ready  = tx_ready_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-banged SPI master plus a word-level model of rx words and the tx shadow.
module tb_spi_slave;

    localparam int W     = 16;
    localparam int H     = 5;   // sclk half period in clk cycles
    localparam int CLK_P = 10;

    logic         clk = 1'b0;
    logic         rst, ss, sclk, mosi, miso;
    logic [W-1:0] rx_data, tx_data;
    logic         rx_valid, tx_load, tx_ready, frame_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] rx_seen[$];
    int           ferr_cnt;
    int           lat_last;
    time          t_rise;

    logic         m_full;
    logic [W-1:0] m_shadow;
    logic [W-1:0] m_last_rx;

    spi_slave #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_seen.push_back(rx_data);
            lat_last = int'(($time - t_rise) / CLK_P);
        end
        if (frame_err) ferr_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_load(input logic [W-1:0] v);
        if (!m_full) begin
            m_shadow = v;
            m_full   = 1'b1;
        end
    endfunction

    function automatic logic [W-1:0] m_take();
        m_take = m_full ? m_shadow : '0;
        m_full = 1'b0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [W-1:0] v);
        tx_data = v;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        m_load(v);
        chk("tx_ready_after_load", tx_ready, !m_full);
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int n, output logic [W-1:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            mosi = w[W-1-i];
            tick(H);
            sclk   = 1'b1;
            t_rise = $time;
            got    = {got[W-2:0], miso};
            tick(H);
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int nw, input logic [W-1:0] w0, input logic [W-1:0] w1,
                             input logic [W-1:0] w2, input bit mid, input logic [W-1:0] mid_v);
        logic [W-1:0] words[3];
        logic [W-1:0] exp_tx, got;
        words[0] = w0;
        words[1] = w1;
        words[2] = w2;
        rx_seen.delete();
        ferr_cnt = 0;
        ss = 1'b0;
        exp_tx = m_take();
        tick(H);
        if (mid) do_load(mid_v);
        for (int k = 0; k < nw; k++) begin
            lat_last = -1;
            send_bits(words[k], W, got);
            chk("miso_word", got, exp_tx);
            chk("rx_latency", lat_last, 3);
            exp_tx    = m_take();
            m_last_rx = words[k];
        end
        tick(H);
        ss = 1'b1;
        tick(2 * H);
        chk("rx_valid_count", rx_seen.size(), nw);
        for (int k = 0; k < nw; k++)
            chk("rx_word", (k < rx_seen.size()) ? rx_seen[k] : 16'hxxxx, words[k]);
        chk("frame_err_clean", ferr_cnt, 0);
        chk("rx_data_hold", rx_data, m_last_rx);
        chk("tx_ready_end", tx_ready, !m_full);
        chk("miso_idle_end", miso, 1'b0);
    endtask

    initial begin
        logic [W-1:0] got, prior;
        rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tx_load = 1'b0; tx_data = '0;
        m_full = 1'b0; m_shadow = '0; m_last_rx = '0;
        ferr_cnt = 0; lat_last = -1; t_rise = 0;
        tick(3);
        chk("rst_rx_data", rx_data, '0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_miso", miso, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_frame_err", frame_err, 1'b0);
        rst = 1'b0;
        tick(4);

        // Single word
        do_load(16'hA55A);
        run_frame(1, 16'h1234, '0, '0, 1'b0, '0);

        // Back-to-back words in one frame, second tx word loaded mid-frame
        run_frame(2, 16'hBEEF, 16'h0001, '0, 1'b1, 16'h00FF);

        // Aborted frame after 9 bits
        prior = m_last_rx;
        rx_seen.delete();
        ferr_cnt = 0;
        ss = 1'b0;
        void'(m_take());
        tick(H);
        send_bits(W'($urandom), 9, got);
        tick(H);
        ss = 1'b1;
        tick(2 * H);
        chk("abort_frame_err", ferr_cnt, 1);
        chk("abort_no_rx", rx_seen.size(), 0);
        chk("abort_rx_hold", rx_data, prior);
        chk("abort_miso", miso, 1'b0);
        run_frame(1, 16'h5555, '0, '0, 1'b0, '0);

        // Second load while the shadow is full is dropped
        do_load(16'h1111);
        do_load(16'h2222);
        run_frame(1, W'($urandom), '0, '0, 1'b0, '0);
        run_frame(1, W'($urandom), '0, '0, 1'b0, '0);

        // Reset mid-word with ss still low
        do_load(16'h7E7E);
        ss = 1'b0;
        void'(m_take());
        tick(H);
        send_bits(W'($urandom), 7, got);
        tick(2);
        rx_seen.delete();
        ferr_cnt = 0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        m_full = 1'b0;
        m_last_rx = '0;
        tick(6);
        chk("rstmid_no_rx", rx_seen.size(), 0);
        chk("rstmid_no_ferr", ferr_cnt, 0);
        chk("rstmid_miso", miso, 1'b0);
        chk("rstmid_tx_ready", tx_ready, 1'b1);
        chk("rstmid_rx_data", rx_data, '0);
        ss = 1'b1;
        tick(2 * H);
        chk("rstmid_ss_rise_ferr", ferr_cnt, 0);
        run_frame(1, 16'hC3C3, '0, '0, 1'b0, '0);

        // sclk noise while deselected
        rx_seen.delete();
        ferr_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            mosi = 1'($urandom);
            sclk = ~sclk;
            tick(H);
            chk("idle_miso", miso, 1'b0);
        end
        tick(4);
        chk("idle_no_rx", rx_seen.size(), 0);
        chk("idle_no_ferr", ferr_cnt, 0);

        // Randomized frames against the word-level model
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_load(W'($urandom));
                if ($urandom_range(0, 1) == 1) do_load(W'($urandom));
            end
            run_frame($urandom_range(1, 3), W'($urandom), W'($urandom), W'($urandom),
                      1'($urandom_range(0, 1)), W'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
